// File: rtl/reg_file_2r1w.sv
// 32-entry, two-read/one-write register file with registered read data and RdValid.
// Define REG_FILE_WB_BYPASS_EN for write-first bypass on read/write collisions (default: read-first).
module reg_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB,
  output logic              RdValid,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] next_b;

  // Writes to the hardwired zero register are dropped before they reach storage.
  assign wr_ok = WrEn && !(ZERO_REG && (WrAddr == '0));

  always_comb begin
    next_a = mem[RdAddrA];
    next_b = mem[RdAddrB];
`ifdef REG_FILE_WB_BYPASS_EN
    if (wr_ok && (WrAddr == RdAddrA)) next_a = WrData;
    if (wr_ok && (WrAddr == RdAddrB)) next_b = WrData;
`endif
    if (ZERO_REG && (RdAddrA == '0)) next_a = '0;
    if (ZERO_REG && (RdAddrB == '0)) next_b = '0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[WrAddr] <= WrData;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      DataA   <= '0;
      DataB   <= '0;
      RdValid <= 1'b0;
    end else begin
      RdValid <= RdEn;
      if (RdEn) begin
        DataA <= next_a;
        DataB <= next_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: reads push expected data, a negedge monitor pops on RdValid.
// Collision expectations follow REG_FILE_WB_BYPASS_EN when defined.
module tb_reg_file_2r1w;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        Clk;
  logic        Rst_n;
  logic        RdEn;
  logic [4:0]  RdAddrA;
  logic [4:0]  RdAddrB;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic        RdValid;
  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [31:0] WrData;

  logic        muxSel;
  logic [31:0] muxImm;
  logic [31:0] muxC;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  reg_file_2r1w dut (
    .Clk(Clk), .Rst_n(Rst_n), .RdEn(RdEn), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .DataA(DataA), .DataB(DataB), .RdValid(RdValid),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData)
  );

  // Downstream operand mux: DataB on input A, immediate on input B
  assign muxC = muxSel ? muxImm : DataB;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock edge of stimulus; reads enqueue their hand-computed expected data
  task automatic applyStimulus(input logic rd, input logic [4:0] addrA, input logic [4:0] addrB,
                               input logic wr, input logic [4:0] wAddr, input logic [31:0] wData,
                               input logic [31:0] expA, input logic [31:0] expB);
    exp_t e;
    RdEn    = rd;
    RdAddrA = addrA;
    RdAddrB = addrB;
    WrEn    = wr;
    WrAddr  = wAddr;
    WrData  = wData;
    if (rd) begin
      e.a = expA;
      e.b = expB;
      expQ.push_back(e);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, addr, data, 32'd0, 32'd0);
  endtask

  task automatic readRegs(input logic [4:0] addrA, input logic [4:0] addrB,
                          input logic [31:0] expA, input logic [31:0] expB);
    applyStimulus(1'b1, addrA, addrB, 1'b0, 5'd0, 32'd0, expA, expB);
  endtask

  // Monitor: every RdValid cycle must match the oldest outstanding read
  always @(negedge Clk) begin
    exp_t e;
    if (RdValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rdvalid_spurious: got 1 expected 0 (no read pending)");
      end else begin
        e = expQ.pop_front();
        checkOutput("read_dataA", DataA, e.a);
        checkOutput("read_dataB", DataB, e.b);
      end
    end
  end

  initial begin
    Rst_n   = 1'b0;
    RdEn    = 1'b0;
    RdAddrA = '0;
    RdAddrB = '0;
    WrEn    = 1'b0;
    WrAddr  = '0;
    WrData  = '0;
    muxSel  = 1'b0;
    muxImm  = 32'd13;
    #2;
    checkOutput("reset_dataA", DataA, 32'd0);
    checkOutput("reset_dataB", DataB, 32'd0);
    checkOutput("reset_rdvalid", {31'd0, RdValid}, 32'd0);
    #1 Rst_n = 1'b1;

    // Write then read with one-cycle latency, then hold
    writeReg(5'd1, 32'd29);
    writeReg(5'd2, 32'd13);
    readRegs(5'd1, 5'd2, 32'd29, 32'd13);
    idle();
    checkOutput("hold_rdvalid", {31'd0, RdValid}, 32'd0);
    checkOutput("hold_dataA", DataA, 32'd29);
    checkOutput("hold_dataB", DataB, 32'd13);

    // Zero register
    writeReg(5'd0, 32'hFFFF_FFFF);
    readRegs(5'd0, 5'd0, 32'd0, 32'd0);
    idle();

    // Back-to-back reads
    readRegs(5'd1, 5'd2, 32'd29, 32'd13);
    readRegs(5'd2, 5'd1, 32'd13, 32'd29);
    readRegs(5'd1, 5'd1, 32'd29, 32'd29);
    idle();

    // Read/write collision on reg 5; port B reads an unrelated register
    writeReg(5'd5, 32'd7);
`ifdef REG_FILE_WB_BYPASS_EN
    applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 32'd42, 32'd42, 32'd29);
`else
    applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 32'd42, 32'd7, 32'd29);
`endif
    readRegs(5'd5, 5'd5, 32'd42, 32'd42);
    // Collision on the zero register still returns 0
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'h55, 32'd0, 32'd0);
    idle();

    // Operand mux pairing
    writeReg(5'd4, 32'd29);
    readRegs(5'd1, 5'd4, 32'd29, 32'd29);
    idle();
    muxSel = 1'b0;
    #1 checkOutput("mux_sel0", muxC, 32'd29);
    muxSel = 1'b1;
    #1 checkOutput("mux_sel1", muxC, 32'd13);
    muxSel = 1'b0;

    // Asynchronous reset mid-cycle
    writeReg(5'd3, 32'd29);
    readRegs(5'd3, 5'd3, 32'd29, 32'd29);
    RdEn = 1'b0;
    #5;
    checkOutput("pre_reset_rdvalid", {31'd0, RdValid}, 32'd1);
    Rst_n = 1'b0;
    #1;
    checkOutput("async_reset_dataA", DataA, 32'd0);
    checkOutput("async_reset_dataB", DataB, 32'd0);
    checkOutput("async_reset_rdvalid", {31'd0, RdValid}, 32'd0);
    #1 Rst_n = 1'b1;
    readRegs(5'd3, 5'd2, 32'd0, 32'd0);
    idle();
    idle();

    // Drain: every queued read must have been observed
    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge Clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending reads expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry general-purpose register file: two synchronous read ports, one write port.
- Sits directly upstream of the 32-bit 2:1 operand mux (Sel/A/B/C) in the execute path.
- DataA feeds the ALU first operand. DataB feeds mux input A; the immediate feeds mux input B.
- Write port is driven by the write-back stage.

Parameters:
DATA_W, 32, width of each register and of data ports
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, when 1 register 0 is hardwired to zero

Ports:
Clk  input  1  rising-edge clock, single clock domain
Rst_n  input  1  asynchronous active-low reset
RdEn  input  1  read request; captures both read addresses this cycle
RdAddrA  input  ADDR_W  read port A address
RdAddrB  input  ADDR_W  read port B address
DataA  output  DATA_W  registered read data, port A
DataB  output  DATA_W  registered read data, port B (to operand mux input A)
RdValid  output  1  high for one cycle when DataA/DataB carry fresh data
WrEn  input  1  write strobe
WrAddr  input  ADDR_W  write address
WrData  input  DATA_W  write data

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst_n is asynchronous and active-low.
- Reset (Rst_n=0, asynchronous, takes effect immediately regardless of Clk):
  - all storage entries clear to 0;
  - DataA = 0, DataB = 0, RdValid = 0.
- Reset release: first operation is honoured on the first rising Clk edge with Rst_n=1.
- Write:
  - on rising Clk with WrEn=1, mem[WrAddr] <= WrData;
  - WrEn=0: no storage change.
- Zero register: with ZERO_REG=1, a write to address 0 is discarded and reads of address 0 return 0. With ZERO_REG=0, entry 0 is an ordinary register.
- Read:
  - on rising Clk with RdEn=1, DataA <= mem[RdAddrA] and DataB <= mem[RdAddrB];
  - latency is 1 cycle from RdEn to data.
- Read hold: with RdEn=0, DataA/DataB hold their last values.
- RdValid: registered copy of RdEn. High exactly in the cycle after each RdEn=1 cycle, otherwise 0. Back-to-back RdEn keeps it high continuously.
- Same address on both read ports: both ports return the identical value.
- Simultaneous read and write to the same address (same edge): behaviour is set by the optional feature below. Reads of other addresses are unaffected.
- No other hazards exist; writes and reads complete in one cycle, with no backpressure.
- Reset asserted mid-operation: any pending write at the next edge is lost, outputs clear, and RdValid drops asynchronously.

Optional Feature:
- Macro: REG_FILE_WB_BYPASS_EN.
- Defined (write-first bypass): on an edge with RdEn=1 and WrEn=1 where RdAddrX == WrAddr, DataX takes WrData in the same cycle.
  - Applies to each port independently.
  - Excluded when WrAddr=0 and ZERO_REG=1; that case still returns 0.
- Undefined (read-first): the same collision returns the pre-write contents. The new value is visible on the next read.

Test Plan:
- Reset clears storage and outputs:
  - stimulus: assert Rst_n=0 mid-cycle after loading reg 3 = 29;
  - response: DataA/DataB/RdValid go 0 without a Clk edge;
  - then after release, read reg 3 -> DataA=0.
- Write then read with 1-cycle latency:
  - stimulus: write reg 1 = 29 and reg 2 = 13 on successive edges, then RdEn=1 with A=1, B=2;
  - response: next cycle DataA=29, DataB=13, RdValid=1;
  - following cycle, with RdEn=0: RdValid=0, data held at 29/13.
- Zero register:
  - stimulus: write reg 0 = 0xFFFF_FFFF, then read A=0, B=0;
  - response: DataA=DataB=0.
- Read/write collision:
  - stimulus: reg 5 = 7, then on one edge WrEn=1 with WrAddr=5, WrData=42, and RdEn=1 with RdAddrA=5;
  - response with REG_FILE_WB_BYPASS_EN: DataA=42;
  - response without it: DataA=7, and the next read returns 42.
- Back-to-back reads:
  - stimulus: RdEn high for 3 cycles with addresses 1, 2, 1 on port A;
  - response: RdValid high for 3 consecutive cycles; DataA sequence 29, 13, 29.
- Downstream pairing with the operand mux:
  - stimulus: DataB drives mux A, immediate 13 drives mux B, reg 4 = 29;
  - response: Sel=0 -> C=29; Sel=1 -> C=13.
